// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate controller.
// Holds the controller state encoding and the internal timer width helper.
// No logic, no latency, no flow control.
package clk_gate_pkg;

  // Controller states; encoding is fixed so it can be matched in waveforms.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    COUNTDOWN = 2'b01,
    SLEEP     = 2'b10,
    WAKE      = 2'b11
  } gate_state_t;

  // Width needed to hold the larger of the two timer reload values.
  function automatic int tmr_width(input int idle_cycles, input int wake_cycles);
    int max_v;
    max_v = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/clock_gate_timer.sv
// Loadable down-counter with a zero flag, shared by the idle and wake phases.
// Latency: load/decrement visible one clock later; zero flag is combinational from the count.
// Backpressure: none; load wins over decrement, decrement stops at zero.
// Ports:
//   i_clk, i_rst      free-running clock, synchronous active-high reset (count -> 0)
//   i_load/i_load_val load a new count
//   i_dec             decrement by one (ignored at zero)
//   o_zero            count == 0
module clock_gate_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Drives the enable of a clock-gating cell: gates after a programmable idle period, ungates on wake.
// Latency: all outputs registered; gating after IDLE_CYCLES+1 idle edges, wake_ack WAKE_CYCLES edges after ungating.
// Backpressure: none; wake_req is a level request acknowledged by a one-cycle wake_ack pulse.
// Ports:
//   clk, rst        free-running clock, synchronous active-high reset
//   busy            activity from the gated domain
//   sleep_allow     software permission to gate
//   wake_req        level wake request (clk-synchronous)
//   force_on        override that keeps/returns the clock on
//   gate_en         registered enable to the gating cell (1 = running)
//   wake_ack        one-cycle pulse once the gated clock is guaranteed running
//   sleeping        high while gated
//   sleep_count     saturating count of gating events
module clock_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 sleep_allow,
  input  logic                 wake_req,
  input  logic                 force_on,
  output logic                 gate_en,
  output logic                 wake_ack,
  output logic                 sleeping,
  output logic [CNT_WIDTH-1:0] sleep_count
);

  localparam int TMR_WIDTH = tmr_width(IDLE_CYCLES, WAKE_CYCLES);

  gate_state_t          r_state;
  gate_state_t          w_next;
  logic                 r_gate_en;
  logic                 r_wake_ack;
  logic                 r_sleeping;
  logic [CNT_WIDTH-1:0] r_sleep_count;

  logic                 w_idle_ok;
  logic                 w_tmr_load;
  logic [TMR_WIDTH-1:0] w_tmr_load_val;
  logic                 w_tmr_dec;
  logic                 w_tmr_zero;
  logic                 w_ack_nxt;
  logic                 w_sleep_inc;

  // A wake request or override in flight disqualifies the cycle as idle,
  // which is what lets them abort a countdown even on its final cycle.
  assign w_idle_ok = !busy && sleep_allow && !wake_req && !force_on;

  clock_gate_timer #(
    .WIDTH (TMR_WIDTH)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_next         = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_dec      = 1'b0;
    w_ack_nxt      = 1'b0;
    w_sleep_inc    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_idle_ok) begin
          w_next         = COUNTDOWN;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_WIDTH'(IDLE_CYCLES - 1);
        end
      end
      COUNTDOWN: begin
        if (!w_idle_ok) begin
          w_next = RUN;
        end else if (w_tmr_zero) begin
          w_next      = SLEEP;
          w_sleep_inc = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      SLEEP: begin
        // busy is meaningless here: the gated domain is frozen.
        if (wake_req || force_on) begin
          w_next         = WAKE;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_WIDTH'(WAKE_CYCLES - 1);
        end
      end
      WAKE: begin
        // Fixed-length guard covering the gating cell's enable synchronizer.
        if (w_tmr_zero) begin
          w_next    = RUN;
          w_ack_nxt = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_gate_en     <= 1'b1;
      r_wake_ack    <= 1'b0;
      r_sleeping    <= 1'b0;
      r_sleep_count <= '0;
    end else begin
      r_state    <= w_next;
      r_gate_en  <= (w_next != SLEEP);
      r_sleeping <= (w_next == SLEEP);
      r_wake_ack <= w_ack_nxt;
      if (w_sleep_inc && (r_sleep_count != '1)) begin
        r_sleep_count <= r_sleep_count + CNT_WIDTH'(1);
      end
    end
  end

  assign gate_en     = r_gate_en;
  assign wake_ack    = r_wake_ack;
  assign sleeping    = r_sleeping;
  assign sleep_count = r_sleep_count;

endmodule
